knn_system: RTL and testbench

K-nearest-neighbour inference engine for fixed-size M×N matrices. It accepts L labelled training matrices one at a time, each paired with the same unlabelled input matrix. Data arrives in chunks of up to MAX_ELEMENTS elements under a read_done/data_request handshake. For each training sample it computes a Manhattan distance to the input and keeps the K nearest. After L samples it outputs the majority-vote class.

---
 rtl/knn_system_if.sv | 28 ++
 rtl/knn_system.sv | 217 +++++++++++++++++++++
 tb/tb_knn_system.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/knn_system_if.sv
// Data/handshake bundle between a training-data sender and the knn_system engine.
// The sender drives chunks and read_done; the engine answers with request/done/result pulses.
interface knn_system_if #(
  parameter int M      = 5,
  parameter int N      = 10,
  parameter int W      = 32,
  parameter int TYPE_W = 3
);
  logic              read_done;
  logic [W-1:0]      training_data [0:M*N-1];
  logic [TYPE_W-1:0] training_data_type;
  logic [W-1:0]      input_data [0:M*N-1];
  logic              data_request;
  logic              done;
  logic              done_calc;
  logic [TYPE_W-1:0] inferred_type;
  logic              inference_done;

  modport master (
    output read_done, training_data, training_data_type, input_data,
    input  data_request, done, done_calc, inferred_type, inference_done
  );

  modport slave (
    input  read_done, training_data, training_data_type, input_data,
    output data_request, done, done_calc, inferred_type, inference_done
  );
endinterface

// File: rtl/knn_system.sv
// K-nearest-neighbour engine: chunked Manhattan distance, sorted K-entry list,
// majority vote over the list after L training samples.
module knn_system #(
  parameter int M            = 5,
  parameter int N            = 10,
  parameter int W            = 32,
  parameter int MAX_ELEMENTS = 32,
  parameter int TYPE_W       = 3,
  parameter int K            = 7,
  parameter int L            = 32
) (
  input  logic        clk,
  input  logic        rst,
  knn_system_if.slave bus
);

  localparam int MN       = M * N;
  localparam int NCHUNK   = (MN + MAX_ELEMENTS - 1) / MAX_ELEMENTS;
  localparam int LAST_CNT = MN - (NCHUNK - 1) * MAX_ELEMENTS;
  localparam int LANES    = (MAX_ELEMENTS < MN) ? MAX_ELEMENTS : MN;
  localparam int ACC_W    = W + $clog2(MN + 1);
  localparam int CIDX_W   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int SCNT_W   = $clog2(L + 1);
  localparam int NTYPES   = 1 << TYPE_W;
  localparam int VCNT_W   = $clog2(K + 1);

  localparam logic [CIDX_W-1:0] LAST_CHUNK  = CIDX_W'(NCHUNK - 1);
  localparam logic [SCNT_W-1:0] LAST_SAMPLE = SCNT_W'(L - 1);

  typedef enum logic [1:0] {
    COLLECT,
    INSERT,
    VOTE
  } state_t;

  state_t              state_reg, state_next;

  logic [ACC_W-1:0]    acc_reg;
  logic [ACC_W-1:0]    dist_reg;
  logic [TYPE_W-1:0]   type_reg;
  logic [CIDX_W-1:0]   chunk_idx_reg;
  logic [SCNT_W-1:0]   sample_cnt_reg;

  logic [ACC_W-1:0]    list_dist_reg   [K];
  logic [TYPE_W-1:0]   list_type_reg   [K];
  logic                list_valid_reg  [K];
  logic [ACC_W-1:0]    list_dist_next  [K];
  logic [TYPE_W-1:0]   list_type_next  [K];
  logic                list_valid_next [K];
  logic                ahead           [K];

  logic                data_request_reg;
  logic                done_reg;
  logic                done_calc_reg;
  logic [TYPE_W-1:0]   inferred_type_reg;
  logic                inference_done_reg;

  logic                last_chunk;
  logic                last_sample;
  logic [W-1:0]        lane_diff [LANES];
  logic [ACC_W-1:0]    chunk_sum;
  logic [VCNT_W-1:0]   vote_cnt  [NTYPES];
  logic [VCNT_W-1:0]   best_cnt;
  logic [TYPE_W-1:0]   vote_type;

  assign last_chunk  = (chunk_idx_reg == LAST_CHUNK);
  assign last_sample = (sample_cnt_reg == LAST_SAMPLE);

  // Per-lane absolute difference; lanes beyond the short final chunk contribute zero.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    localparam bit IN_LAST = (gi < LAST_CNT);
    logic [W-1:0] a, b;
    assign a = bus.training_data[gi];
    assign b = bus.input_data[gi];
    assign lane_diff[gi] = (last_chunk && !IN_LAST) ? '0
                         : ((a >= b) ? (a - b) : (b - a));
  end

  always_comb begin
    chunk_sum = '0;
    for (int e = 0; e < LANES; e++) begin
      chunk_sum = chunk_sum + ACC_W'(lane_diff[e]);
    end
  end

  // An entry stays ahead of the newcomer unless the newcomer is strictly closer.
  for (genvar gi = 0; gi < K; gi++) begin : g_ins
    assign ahead[gi] = list_valid_reg[gi] && !(dist_reg < list_dist_reg[gi]);
    if (gi == 0) begin : g_head
      assign list_dist_next[gi]  = ahead[gi] ? list_dist_reg[gi] : dist_reg;
      assign list_type_next[gi]  = ahead[gi] ? list_type_reg[gi] : type_reg;
      assign list_valid_next[gi] = 1'b1;
    end else begin : g_tail
      assign list_dist_next[gi]  = ahead[gi]     ? list_dist_reg[gi]
                                 : ahead[gi-1]   ? dist_reg
                                 : list_dist_reg[gi-1];
      assign list_type_next[gi]  = ahead[gi]     ? list_type_reg[gi]
                                 : ahead[gi-1]   ? type_reg
                                 : list_type_reg[gi-1];
      assign list_valid_next[gi] = ahead[gi]     ? list_valid_reg[gi]
                                 : ahead[gi-1]   ? 1'b1
                                 : list_valid_reg[gi-1];
    end
  end

  for (genvar gi = 0; gi < NTYPES; gi++) begin : g_vote
    logic [VCNT_W-1:0] cnt;
    always_comb begin
      cnt = '0;
      for (int i = 0; i < K; i++) begin
        if (list_valid_reg[i] && (list_type_reg[i] == TYPE_W'(gi))) begin
          cnt = cnt + 1'b1;
        end
      end
    end
    assign vote_cnt[gi] = cnt;
  end

  // Ascending scan with strict compare lets the lowest label win a tie.
  always_comb begin
    best_cnt  = '0;
    vote_type = '0;
    for (int t = 0; t < NTYPES; t++) begin
      if (vote_cnt[t] > best_cnt) begin
        best_cnt  = vote_cnt[t];
        vote_type = TYPE_W'(t);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= COLLECT;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      COLLECT: if (bus.read_done && last_chunk) state_next = INSERT;
      INSERT:  state_next = last_sample ? VOTE : COLLECT;
      VOTE:    state_next = COLLECT;
      default: state_next = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg            <= '0;
      dist_reg           <= '0;
      type_reg           <= '0;
      chunk_idx_reg      <= '0;
      sample_cnt_reg     <= '0;
      data_request_reg   <= 1'b0;
      done_reg           <= 1'b0;
      done_calc_reg      <= 1'b0;
      inferred_type_reg  <= '0;
      inference_done_reg <= 1'b0;
      for (int i = 0; i < K; i++) begin
        list_dist_reg[i]  <= '0;
        list_type_reg[i]  <= '0;
        list_valid_reg[i] <= 1'b0;
      end
    end else begin
      data_request_reg   <= 1'b0;
      done_reg           <= 1'b0;
      done_calc_reg      <= 1'b0;
      inference_done_reg <= 1'b0;
      case (state_reg)
        COLLECT: begin
          if (bus.read_done) begin
            type_reg <= bus.training_data_type;
            if (last_chunk) begin
              dist_reg      <= acc_reg + chunk_sum;
              acc_reg       <= '0;
              chunk_idx_reg <= '0;
            end else begin
              acc_reg          <= acc_reg + chunk_sum;
              chunk_idx_reg    <= chunk_idx_reg + 1'b1;
              data_request_reg <= 1'b1;
            end
          end
        end
        INSERT: begin
          for (int i = 0; i < K; i++) begin
            list_dist_reg[i]  <= list_dist_next[i];
            list_type_reg[i]  <= list_type_next[i];
            list_valid_reg[i] <= list_valid_next[i];
          end
          done_reg       <= 1'b1;
          done_calc_reg  <= last_sample;
          sample_cnt_reg <= sample_cnt_reg + 1'b1;
        end
        VOTE: begin
          inferred_type_reg  <= vote_type;
          inference_done_reg <= 1'b1;
          sample_cnt_reg     <= '0;
          acc_reg            <= '0;
          chunk_idx_reg      <= '0;
          for (int i = 0; i < K; i++) begin
            list_valid_reg[i] <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.data_request   = data_request_reg;
  assign bus.done           = done_reg;
  assign bus.done_calc      = done_calc_reg;
  assign bus.inferred_type  = inferred_type_reg;
  assign bus.inference_done = inference_done_reg;

endmodule

// File: tb/tb_knn_system.sv
// Directed self-checking bench for knn_system: handshake timing, voting scenarios,
// back-to-back inferences and mid-run reset.
module tb_knn_system;

  localparam int M      = 5;
  localparam int N      = 10;
  localparam int W      = 32;
  localparam int TYPE_W = 3;
  localparam int MN     = M * N;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  int dreq_total = 0;
  int done_total = 0;
  int calc_total = 0;
  int infd_total = 0;

  always #5 clk = ~clk;

  knn_system_if #(.M(M), .N(N), .W(W), .TYPE_W(TYPE_W)) bus ();

  knn_system #(
    .M(M), .N(N), .W(W), .MAX_ELEMENTS(32), .TYPE_W(TYPE_W), .K(7), .L(32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always @(negedge clk) begin
    if (bus.data_request === 1'b1)   dreq_total++;
    if (bus.done === 1'b1)           done_total++;
    if (bus.done_calc === 1'b1)      calc_total++;
    if (bus.inference_done === 1'b1) infd_total++;
  end

  // Used lanes carry the sample value; ignored lanes carry garbage that must not count.
  task automatic drive_chunk(input int unsigned tv, input int unsigned lbl,
                             input int unsigned iv, input int used);
    for (int e = 0; e < MN; e++) begin
      bus.training_data[e] = (e < used) ? W'(tv) : 32'hFFFF_FFFF;
      bus.input_data[e]    = (e < used) ? W'(iv) : 32'h0;
    end
    bus.training_data_type = TYPE_W'(lbl);
  endtask

  task automatic do_sample(input int unsigned tv, input int unsigned lbl,
                           input int unsigned iv, input bit last, input string tag);
    drive_chunk(tv, lbl, iv, 32);
    bus.read_done = 1'b1;
    @(negedge clk);
    bus.read_done = 1'b0;
    checks++;
    if (bus.data_request !== 1'b1) begin
      errors++;
      $display("FAIL %s data_request_after_chunk0: got %0b required 1", tag, bus.data_request);
    end
    @(negedge clk);
    checks++;
    if (bus.data_request !== 1'b0) begin
      errors++;
      $display("FAIL %s data_request_width: got %0b required 0", tag, bus.data_request);
    end
    drive_chunk(tv, lbl, iv, 18);
    bus.read_done = 1'b1;
    @(negedge clk);
    bus.read_done = 1'b0;
    checks++;
    if (bus.done !== 1'b0 || bus.data_request !== 1'b0) begin
      errors++;
      $display("FAIL %s insert_cycle: done=%0b data_request=%0b required 0 0",
               tag, bus.done, bus.data_request);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b1 || bus.done_calc !== last) begin
      errors++;
      $display("FAIL %s done_pulse: done=%0b done_calc=%0b required 1 %0b",
               tag, bus.done, bus.done_calc, last);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.done_calc !== 1'b0) begin
      errors++;
      $display("FAIL %s done_width: done=%0b done_calc=%0b required 0 0",
               tag, bus.done, bus.done_calc);
    end
  endtask

  task automatic run_groups(input string tag, input int n[4], input int unsigned tv[4],
                            input int unsigned lbl[4], input int unsigned iv,
                            input int unsigned exp_type);
    int total;
    int idx;
    total = n[0] + n[1] + n[2] + n[3];
    idx = 0;
    for (int g = 0; g < 4; g++) begin
      for (int k = 0; k < n[g]; k++) begin
        idx++;
        do_sample(tv[g], lbl[g], iv, idx == total, tag);
      end
    end
    checks++;
    if (bus.inference_done !== 1'b1 || bus.inferred_type !== TYPE_W'(exp_type)) begin
      errors++;
      $display("FAIL %s inference: inference_done=%0b inferred_type=%0d required 1 %0d",
               tag, bus.inference_done, bus.inferred_type, exp_type);
    end
    @(negedge clk);
    checks++;
    if (bus.inference_done !== 1'b0 || bus.inferred_type !== TYPE_W'(exp_type)) begin
      errors++;
      $display("FAIL %s inference_hold: inference_done=%0b inferred_type=%0d required 0 %0d",
               tag, bus.inference_done, bus.inferred_type, exp_type);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    checks++;
    if (bus.data_request !== 1'b0 || bus.done !== 1'b0 || bus.done_calc !== 1'b0 ||
        bus.inferred_type !== '0 || bus.inference_done !== 1'b0) begin
      errors++;
      $display("FAIL %s outputs: req=%0b done=%0b calc=%0b type=%0d infd=%0b required all 0",
               tag, bus.data_request, bus.done, bus.done_calc, bus.inferred_type,
               bus.inference_done);
    end
  endtask

  task automatic test_reset();
    bus.read_done = 1'b0;
    drive_chunk(0, 0, 0, MN);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset_held");
    rst = 1'b0;
    @(negedge clk);
    check_outputs_zero("reset_released");
  endtask

  task automatic test_handshake();
    int d0, n0, c0, i0;
    #1;
    d0 = dreq_total; n0 = done_total; c0 = calc_total; i0 = infd_total;
    @(negedge clk);
    run_groups("handshake", '{7, 25, 0, 0}, '{30, 90, 0, 0}, '{2, 5, 0, 0}, 25, 2);
    #1;
    checks++;
    if ((dreq_total - d0) != 32 || (done_total - n0) != 32 ||
        (calc_total - c0) != 1 || (infd_total - i0) != 1) begin
      errors++;
      $display("FAIL handshake_counts: req=%0d done=%0d calc=%0d infd=%0d required 32 32 1 1",
               dreq_total - d0, done_total - n0, calc_total - c0, infd_total - i0);
    end
    @(negedge clk);
  endtask

  task automatic test_basic_inference();
    run_groups("basic", '{7, 25, 0, 0}, '{30, 90, 0, 0}, '{2, 5, 0, 0}, 25, 2);
  endtask

  task automatic test_majority();
    run_groups("majority", '{3, 4, 25, 0}, '{24, 50, 100, 0}, '{2, 3, 5, 0}, 25, 3);
  endtask

  task automatic test_vote_tie();
    run_groups("vote_tie", '{3, 3, 1, 25}, '{10, 30, 70, 100}, '{1, 2, 4, 5}, 25, 1);
  endtask

  task automatic test_back_to_back();
    run_groups("b2b_run1", '{7, 25, 0, 0}, '{30, 90, 0, 0}, '{2, 5, 0, 0}, 25, 2);
    // Far samples first, so the near ones must displace them.
    run_groups("b2b_run2", '{25, 7, 0, 0}, '{10, 95, 0, 0}, '{1, 5, 0, 0}, 100, 5);
  endtask

  task automatic test_reset_mid_run();
    for (int i = 0; i < 10; i++) begin
      do_sample(25, 6, 25, 1'b0, "abort");
    end
    drive_chunk(1000, 6, 25, 32);
    bus.read_done = 1'b1;
    @(negedge clk);
    bus.read_done = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_outputs_zero("reset_mid_run");
    run_groups("after_reset", '{3, 3, 1, 25}, '{10, 30, 70, 100}, '{1, 2, 4, 5}, 25, 1);
  endtask

  initial begin
    test_reset();
    test_handshake();
    test_basic_inference();
    test_majority();
    test_vote_tie();
    test_back_to_back();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
